// File: rtl/exe_stage_pkg.sv
// Shared constants for the execute stage: bus widths, field indices, divider states.
// Also hosts the store lane helpers so the byte-lane policy lives in one place.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 161;
    localparam int ES_TO_MS_BUS_WD = 119;
    localparam int ES_FWD_BUS_WD   = 39;

    localparam int EXT_LB  = 0;
    localparam int EXT_LBU = 1;
    localparam int EXT_LH  = 2;
    localparam int EXT_LHU = 3;
    localparam int EXT_LWL = 4;
    localparam int EXT_LWR = 5;
    localparam int EXT_SB  = 6;
    localparam int EXT_SH  = 7;
    localparam int EXT_SWL = 8;
    localparam int EXT_SWR = 9;

    localparam int MD_MULT  = 0;
    localparam int MD_MULTU = 1;
    localparam int MD_DIV   = 2;
    localparam int MD_DIVU  = 3;
    localparam int MD_MTHI  = 4;
    localparam int MD_MTLO  = 5;

    localparam int HR_MFHI = 0;
    localparam int HR_MFLO = 1;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // First field is the MSB of the decode->execute bus.
    typedef struct packed {
        logic [1:0]  hilo_rd;
        logic [5:0]  md_op;
        logic [15:0] extend_bus;
        logic [11:0] alu_op;
        logic        imm_zext;
        logic        src2_is_8;
        logic        src2_is_imm;
        logic        src1_is_pc;
        logic        src1_is_sa;
        logic        res_from_mem;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [31:0] pc;
    } ds_bus_t;

    function automatic logic [3:0] store_wen(input logic [15:0] ext, input logic [1:0] off);
        logic [3:0] w;
        w = 4'b1111;
        if (ext[EXT_SB])       w = 4'b0001 << off;
        else if (ext[EXT_SH])  w = off[1] ? 4'b1100 : 4'b0011;
        else if (ext[EXT_SWL]) w = 4'b1111 >> (2'd3 - off);
        else if (ext[EXT_SWR]) w = 4'b1111 << off;
        return w;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [15:0] ext, input logic [31:0] rt,
                                                input logic [1:0] off);
        logic [31:0] d;
        d = rt;
        if (ext[EXT_SB])       d = {4{rt[7:0]}};
        else if (ext[EXT_SH])  d = {2{rt[15:0]}};
        else if (ext[EXT_SWL]) d = rt >> {(2'd3 - off), 3'b000};
        else if (ext[EXT_SWR]) d = rt << {off, 3'b000};
        return d;
    endfunction

endpackage

// File: rtl/alu.sv
// Twelve-op integer ALU; alu_op is one-hot, results of selected ops are OR-ed together.
module alu
    import exe_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic [31:0] add_r;
    logic [31:0] sub_r;
    logic [31:0] slt_r;
    logic [31:0] sltu_r;
    logic [31:0] sra_r;

    assign add_r  = alu_src1 + alu_src2;
    assign sub_r  = alu_src1 - alu_src2;
    assign slt_r  = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
    assign sltu_r = {31'd0, (alu_src1 < alu_src2)};
    assign sra_r  = $signed(alu_src2) >>> alu_src1[4:0];

    always_comb begin
        alu_result = 32'd0;
        if (alu_op[ALU_ADD])  alu_result = alu_result | add_r;
        if (alu_op[ALU_SUB])  alu_result = alu_result | sub_r;
        if (alu_op[ALU_SLT])  alu_result = alu_result | slt_r;
        if (alu_op[ALU_SLTU]) alu_result = alu_result | sltu_r;
        if (alu_op[ALU_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[ALU_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[ALU_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[ALU_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[ALU_SLL])  alu_result = alu_result | (alu_src2 << alu_src1[4:0]);
        if (alu_op[ALU_SRL])  alu_result = alu_result | (alu_src2 >> alu_src1[4:0]);
        if (alu_op[ALU_SRA])  alu_result = alu_result | sra_r;
        if (alu_op[ALU_LUI])  alu_result = alu_result | {alu_src2[15:0], 16'd0};
    end

endmodule

// File: rtl/exe_stage_div_unit.sv
// div_unit: radix-2 restoring divider on magnitudes, 32 iterations, sign fix-up on output.
// Results stay stable in DONE until ack; divide by zero yields quotient all-ones, remainder = dividend.
module div_unit
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state;
    div_state_e  state_next;
    logic [4:0]  cnt;
    logic [31:0] q_reg;
    logic [31:0] r_reg;
    logic [31:0] d_reg;
    logic        q_neg;
    logic        r_neg;
    logic        by_zero;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [32:0] trial;

    assign dividend_mag = (signed_op && dividend[31]) ? -dividend : dividend;
    assign divisor_mag  = (signed_op && divisor[31])  ? -divisor  : divisor;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (cnt == 5'd31) state_next = DONE;
            DONE:    if (ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Borrow out of the 33-bit trial subtraction means the divisor did not fit.
    assign trial = {r_reg, q_reg[31]} - {1'b0, d_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 5'd0;
            q_reg   <= 32'd0;
            r_reg   <= 32'd0;
            d_reg   <= 32'd0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            by_zero <= 1'b0;
        end else if (state == IDLE && start) begin
            cnt     <= 5'd0;
            q_reg   <= dividend_mag;
            r_reg   <= 32'd0;
            d_reg   <= divisor_mag;
            q_neg   <= signed_op & (dividend[31] ^ divisor[31]);
            r_neg   <= signed_op & dividend[31];
            by_zero <= (divisor == 32'd0);
        end else if (state == BUSY) begin
            cnt <= cnt + 5'd1;
            if (!trial[32]) begin
                r_reg <= trial[31:0];
                q_reg <= {q_reg[30:0], 1'b1};
            end else begin
                r_reg <= {r_reg[30:0], q_reg[31]};
                q_reg <= {q_reg[30:0], 1'b0};
            end
        end
    end

    assign done      = (state == DONE);
    assign quotient  = by_zero ? 32'hFFFF_FFFF : (q_neg ? -q_reg : q_reg);
    assign remainder = r_neg ? -r_reg : r_reg;

endmodule

// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage - ALU, store lane alignment, SRAM request, HI/LO and divider stall.
// Define MULDIV_EN to build HI/LO, the multiplier and div_unit; otherwise mult/div/mf/mt are ignored.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_FWD_BUS_WD-1:0]   es_to_ds_fwd,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    // valid/ready: an instruction moves on a clock edge when the sender's valid and the
    // receiver's allowin are both high; valid is never withdrawn while waiting.
    logic        es_valid;
    logic        es_ready_go;
    logic        handoff;
    ds_bus_t     ds_r;
    logic [31:0] imm_ext;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_result;
    logic [31:0] es_result;
    logic [1:0]  off;

    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign handoff        = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk) begin
        if (reset)           es_valid <= 1'b0;
        else if (es_allowin) es_valid <= ds_to_es_valid;
    end

    always_ff @(posedge clk) begin
        if (reset)                             ds_r <= '0;
        else if (ds_to_es_valid && es_allowin) ds_r <= ds_bus_t'(ds_to_es_bus);
    end

    assign imm_ext  = ds_r.imm_zext ? {16'd0, ds_r.imm} : {{16{ds_r.imm[15]}}, ds_r.imm};
    assign alu_src1 = ds_r.src1_is_sa ? {27'd0, ds_r.imm[10:6]} :
                      ds_r.src1_is_pc ? ds_r.pc : ds_r.rs_value;
    assign alu_src2 = ds_r.src2_is_8   ? 32'd8 :
                      ds_r.src2_is_imm ? imm_ext : ds_r.rt_value;

    alu u_alu (
        .alu_op     (ds_r.alu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (alu_result)
    );

`ifdef MULDIV_EN
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_done;
    logic        is_div;
    logic        is_mul;

    assign is_div = ds_r.md_op[MD_DIV]  | ds_r.md_op[MD_DIVU];
    assign is_mul = ds_r.md_op[MD_MULT] | ds_r.md_op[MD_MULTU];

    // Operands widened first so the signed product is exact in 64 bits.
    assign prod_s = $signed({{32{ds_r.rs_value[31]}}, ds_r.rs_value}) *
                    $signed({{32{ds_r.rt_value[31]}}, ds_r.rt_value});
    assign prod_u = {32'd0, ds_r.rs_value} * {32'd0, ds_r.rt_value};

    div_unit u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (es_valid & is_div),
        .signed_op (ds_r.md_op[MD_DIV]),
        .dividend  (ds_r.rs_value),
        .divisor   (ds_r.rt_value),
        .ack       (handoff),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign es_ready_go = !is_div || div_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (handoff) begin
            if (is_mul) begin
                {hi, lo} <= ds_r.md_op[MD_MULT] ? prod_s : prod_u;
            end else if (is_div) begin
                hi <= remainder;
                lo <= quotient;
            end else begin
                if (ds_r.md_op[MD_MTHI]) hi <= ds_r.rs_value;
                if (ds_r.md_op[MD_MTLO]) lo <= ds_r.rs_value;
            end
        end
    end

    assign es_result = ds_r.hilo_rd[HR_MFHI] ? hi :
                       ds_r.hilo_rd[HR_MFLO] ? lo : alu_result;
`else
    logic md_unused;

    assign md_unused   = ^{ds_r.md_op, ds_r.hilo_rd};
    assign es_ready_go = 1'b1;
    assign es_result   = alu_result;
`endif

    assign es_to_ms_bus = es_to_ms_valid ?
        {ds_r.rt_value, ds_r.extend_bus, ds_r.res_from_mem, ds_r.gr_we, ds_r.dest, es_result, ds_r.pc} :
        '0;
    assign es_to_ds_fwd = (es_valid && ds_r.gr_we) ?
        {1'b1, ds_r.res_from_mem, ds_r.dest, es_result} : '0;

    assign off             = alu_result[1:0];
    assign data_sram_en    = es_valid && (ds_r.mem_we || ds_r.res_from_mem);
    assign data_sram_wen   = (es_valid && ds_r.mem_we) ? store_wen(ds_r.extend_bus, off) : 4'b0000;
    assign data_sram_addr  = {alu_result[31:2], 2'b00};
    assign data_sram_wdata = store_wdata(ds_r.extend_bus, ds_r.rt_value, off);

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: vector table for single-cycle ops and stores,
// hand-written sequences for divider latency, stalls, HI/LO and reset.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic         clk;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [160:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [118:0] es_to_ms_bus;
    logic [38:0]  es_to_ds_fwd;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int passed = 0;
    int total  = 0;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_to_ds_fwd    (es_to_ds_fwd),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam int OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_AND = 4, OP_NOR = 5;
    localparam int OP_OR = 6, OP_XOR = 7, OP_SLL = 8, OP_SRL = 9, OP_SRA = 10, OP_LUI = 11;
    localparam logic [7:0] C_IMM = 8'h01, C_ZX = 8'h02, C_SA = 8'h04, C_PC = 8'h08;
    localparam logic [7:0] C_8 = 8'h10, C_MW = 8'h20, C_RM = 8'h40, C_WE = 8'h80;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  dest;
        logic        gr_we, mem_we, res_from_mem, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, imm_zext;
        logic [11:0] alu_op;
        logic [15:0] ext;
        logic [5:0]  md;
        logic [1:0]  hr;
    } ins_t;

    typedef struct {
        ins_t        ins;
        logic [31:0] res;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } vec_t;

    function automatic ins_t mk(input int op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] imm, input logic [7:0] ctl, input logic [15:0] ext);
        ins_t x;
        x.pc = 32'hBFC0_0000; x.rs = rs; x.rt = rt; x.imm = imm; x.dest = 5'd9;
        x.src2_is_imm = ctl[0]; x.imm_zext = ctl[1]; x.src1_is_sa = ctl[2]; x.src1_is_pc = ctl[3];
        x.src2_is_8 = ctl[4]; x.mem_we = ctl[5]; x.res_from_mem = ctl[6]; x.gr_we = ctl[7];
        x.alu_op = 12'd0; x.alu_op[op] = 1'b1;
        x.ext = ext; x.md = 6'd0; x.hr = 2'd0;
        return x;
    endfunction

    function automatic logic [160:0] pack(input ins_t x);
        return {x.hr, x.md, x.ext, x.alu_op, x.imm_zext, x.src2_is_8, x.src2_is_imm, x.src1_is_pc,
                x.src1_is_sa, x.res_from_mem, x.mem_we, x.gr_we, x.dest, x.imm, x.rs, x.rt, x.pc};
    endfunction

    function automatic ins_t md_ins(input int bit_idx, input logic [31:0] rs, input logic [31:0] rt);
        ins_t x;
        x = mk(OP_ADD, rs, rt, 16'd0, 8'h00, 16'd0);
        x.md[bit_idx] = 1'b1;
        return x;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // driver: present one instruction and hold it until ES accepts it
    task automatic issue(input logic [160:0] b);
        int n;
        n = 0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
        while (!es_allowin && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL issue_timeout: es_allowin low for %0d cycles", n);
        end
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!es_to_ms_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic read_hilo(input int which, output logic [31:0] v);
        ins_t x;
        x = mk(OP_ADD, 32'd3, 32'd4, 16'd0, C_WE, 16'd0);
        x.hr[which] = 1'b1;
        issue(pack(x));
        v = es_to_ms_bus[63:32];
    endtask

    localparam int NV = 25;
    vec_t vt[NV];

    initial begin
        int c;
        logic [31:0] v;
        ins_t x;
        logic [118:0] eb;
        logic [38:0] ef;

        vt[0]  = '{mk(OP_ADD,  32'd5, 32'd7, 16'd0, C_WE, 16'd0), 32'd12, 4'b0000, 32'd0};
        vt[1]  = '{mk(OP_SUB,  32'd5, 32'd7, 16'd0, C_WE, 16'd0), 32'hFFFF_FFFE, 4'b0000, 32'd0};
        vt[2]  = '{mk(OP_SLT,  32'hFFFF_FFFF, 32'd1, 16'd0, C_WE, 16'd0), 32'd1, 4'b0000, 32'd0};
        vt[3]  = '{mk(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 16'd0, C_WE, 16'd0), 32'd0, 4'b0000, 32'd0};
        vt[4]  = '{mk(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 16'd0, C_WE, 16'd0), 32'hF000_F000, 4'b0000, 32'd0};
        vt[5]  = '{mk(OP_NOR,  32'h0F0F_0000, 32'h0000_0F0F, 16'd0, C_WE, 16'd0), 32'hF0F0_F0F0, 4'b0000, 32'd0};
        vt[6]  = '{mk(OP_OR,   32'h1234_0000, 32'h0000_5678, 16'd0, C_WE, 16'd0), 32'h1234_5678, 4'b0000, 32'd0};
        vt[7]  = '{mk(OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 16'd0, C_WE, 16'd0), 32'h5A5A_5A5A, 4'b0000, 32'd0};
        vt[8]  = '{mk(OP_SLL,  32'h0000_DEAD, 32'd1, 16'h0100, C_SA | C_WE, 16'd0), 32'h0000_0010, 4'b0000, 32'd0};
        vt[9]  = '{mk(OP_SRL,  32'd0, 32'h8000_0000, 16'h0100, C_SA | C_WE, 16'd0), 32'h0800_0000, 4'b0000, 32'd0};
        vt[10] = '{mk(OP_SRA,  32'd0, 32'h8000_0000, 16'h0100, C_SA | C_WE, 16'd0), 32'hF800_0000, 4'b0000, 32'd0};
        vt[11] = '{mk(OP_LUI,  32'h5555, 32'd0, 16'h1234, C_IMM | C_WE, 16'd0), 32'h1234_0000, 4'b0000, 32'd0};
        vt[12] = '{mk(OP_ADD,  32'h10, 32'd0, 16'hFFFF, C_IMM | C_WE, 16'd0), 32'h0000_000F, 4'b0000, 32'd0};
        vt[13] = '{mk(OP_ADD,  32'h10, 32'd0, 16'hFFFF, C_IMM | C_ZX | C_WE, 16'd0), 32'h0001_000F, 4'b0000, 32'd0};
        vt[14] = '{mk(OP_ADD,  32'd0, 32'd0, 16'd0, C_PC | C_8 | C_WE, 16'd0), 32'h8000_0018, 4'b0000, 32'd0};
        vt[14].ins.pc = 32'h8000_0010;
        vt[15] = '{mk(OP_ADD,  32'h1000, 32'h1122_3344, 16'd3, C_IMM | C_MW, 16'h0040), 32'h1003, 4'b1000, 32'h4444_4444};
        vt[16] = '{mk(OP_ADD,  32'h1000, 32'h1122_3344, 16'd0, C_IMM | C_MW, 16'h0040), 32'h1000, 4'b0001, 32'h4444_4444};
        vt[17] = '{mk(OP_ADD,  32'h1000, 32'h1122_3344, 16'd2, C_IMM | C_MW, 16'h0080), 32'h1002, 4'b1100, 32'h3344_3344};
        vt[18] = '{mk(OP_ADD,  32'h2000, 32'hAABB_CCDD, 16'd1, C_IMM | C_MW, 16'h0100), 32'h2001, 4'b0011, 32'h0000_AABB};
        vt[19] = '{mk(OP_ADD,  32'h2000, 32'hAABB_CCDD, 16'd3, C_IMM | C_MW, 16'h0100), 32'h2003, 4'b1111, 32'hAABB_CCDD};
        vt[20] = '{mk(OP_ADD,  32'h2000, 32'hAABB_CCDD, 16'd2, C_IMM | C_MW, 16'h0200), 32'h2002, 4'b1100, 32'hCCDD_0000};
        vt[21] = '{mk(OP_ADD,  32'h2000, 32'hAABB_CCDD, 16'd0, C_IMM | C_MW, 16'h0200), 32'h2000, 4'b1111, 32'hAABB_CCDD};
        vt[22] = '{mk(OP_ADD,  32'h3000, 32'h0BAD_F00D, 16'd4, C_IMM | C_MW, 16'h0000), 32'h3004, 4'b1111, 32'h0BAD_F00D};
        vt[23] = '{mk(OP_ADD,  32'h3000, 32'h0BAD_F00D, 16'd8, C_IMM | C_RM | C_WE, 16'h0000), 32'h3008, 4'b0000, 32'd0};
        vt[24] = '{mk(OP_ADD,  32'h2000, 32'hAABB_CCDD, 16'd0, C_IMM | C_MW, 16'h0100), 32'h2000, 4'b0001, 32'h0000_00AA};

        // reset
        reset = 1'b1;
        ms_allowin = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", es_to_ms_valid, 1'b0);
        check("rst_allowin", es_allowin, 1'b1);
        check("rst_en", data_sram_en, 1'b0);
        check("rst_wen", data_sram_wen, 4'b0000);
        check("rst_bus", es_to_ms_bus, 119'd0);
        check("rst_fwd", es_to_ds_fwd, 39'd0);
        reset = 1'b0;

        // table-driven single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            x = vt[i].ins;
            issue(pack(x));
            eb = {x.rt, x.ext, x.res_from_mem, x.gr_we, x.dest, vt[i].res, x.pc};
            ef = x.gr_we ? {1'b1, x.res_from_mem, x.dest, vt[i].res} : 39'd0;
            check($sformatf("v%0d_valid", i), es_to_ms_valid, 1'b1);
            check($sformatf("v%0d_bus", i), es_to_ms_bus, eb);
            check($sformatf("v%0d_fwd", i), es_to_ds_fwd, ef);
            check($sformatf("v%0d_en", i), data_sram_en, x.mem_we | x.res_from_mem);
            check($sformatf("v%0d_wen", i), data_sram_wen, vt[i].wen);
            if (x.mem_we || x.res_from_mem)
                check($sformatf("v%0d_addr", i), data_sram_addr, {vt[i].res[31:2], 2'b00});
            if (x.mem_we)
                check($sformatf("v%0d_wdata", i), data_sram_wdata, vt[i].wdata);
        end
        @(posedge clk); #1;
        check("idle_valid", es_to_ms_valid, 1'b0);
        check("idle_bus", es_to_ms_bus, 119'd0);
        check("idle_fwd", es_to_ds_fwd, 39'd0);
        check("idle_en", data_sram_en, 1'b0);

`ifdef MULDIV_EN
        // div -7 / 2: latency and committed result
        issue(pack(md_ins(MD_DIV, 32'hFFFF_FFF9, 32'd2)));
        check("div_stall", es_allowin, 1'b0);
        wait_valid(c);
        check("div_latency", c, 33);
        check("div_state_done", dut.u_div.state, DONE);
        read_hilo(HR_MFLO, v);
        check("div_lo", v, 32'hFFFF_FFFD);
        read_hilo(HR_MFHI, v);
        check("div_hi", v, 32'hFFFF_FFFF);

        // divu 5 / 0 with memory stage stalled in DONE
        issue(pack(md_ins(MD_DIVU, 32'd5, 32'd0)));
        wait_valid(c);
        check("divu0_latency", c, 33);
        ms_allowin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_valid", k), es_to_ms_valid, 1'b1);
            check($sformatf("stall%0d_state", k), dut.u_div.state, DONE);
            check($sformatf("stall%0d_hi", k), dut.hi, 32'hFFFF_FFFF);
            check($sformatf("stall%0d_lo", k), dut.lo, 32'hFFFF_FFFD);
        end
        ms_allowin = 1'b1;
        read_hilo(HR_MFLO, v);
        check("divu0_lo", v, 32'hFFFF_FFFF);
        read_hilo(HR_MFHI, v);
        check("divu0_hi", v, 32'd5);

        // back-to-back divides
        issue(pack(md_ins(MD_DIV, 32'd100, 32'd7)));
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = pack(md_ins(MD_DIV, 32'hFFFF_FF9C, 32'd7));
        wait_valid(c);
        check("b2b_first_latency", c, 33);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        check("b2b_first_lo", dut.lo, 32'd14);
        check("b2b_first_hi", dut.hi, 32'd2);
        check("b2b_reenter_idle", dut.u_div.state, IDLE);
        wait_valid(c);
        check("b2b_second_latency", c, 33);
        read_hilo(HR_MFLO, v);
        check("b2b_second_lo", v, 32'hFFFF_FFF2);
        read_hilo(HR_MFHI, v);
        check("b2b_second_hi", v, 32'hFFFF_FFFE);

        // multiply and moves
        issue(pack(md_ins(MD_MULTU, 32'hFFFF_FFFF, 32'd2)));
        read_hilo(HR_MFHI, v);
        check("multu_hi", v, 32'd1);
        read_hilo(HR_MFLO, v);
        check("multu_lo", v, 32'hFFFF_FFFE);
        issue(pack(md_ins(MD_MULT, 32'hFFFF_FFFD, 32'd5)));
        read_hilo(HR_MFHI, v);
        check("mult_hi", v, 32'hFFFF_FFFF);
        read_hilo(HR_MFLO, v);
        check("mult_lo", v, 32'hFFFF_FFF1);
        issue(pack(md_ins(MD_MTHI, 32'h1234, 32'd0)));
        read_hilo(HR_MFHI, v);
        check("mthi", v, 32'h1234);
        read_hilo(HR_MFLO, v);
        check("mthi_lo_kept", v, 32'hFFFF_FFF1);
        issue(pack(md_ins(MD_MTLO, 32'hCAFE, 32'd0)));
        read_hilo(HR_MFLO, v);
        check("mtlo", v, 32'hCAFE);

        // reset in the middle of a divide
        issue(pack(md_ins(MD_DIV, 32'd100, 32'd3)));
        repeat (10) begin @(posedge clk); #1; end
        check("middiv_busy", dut.u_div.state, BUSY);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("middiv_state", dut.u_div.state, IDLE);
        check("middiv_cnt", dut.u_div.cnt, 5'd0);
        check("middiv_valid", es_to_ms_valid, 1'b0);
        check("middiv_allowin", es_allowin, 1'b1);
        check("middiv_hi", dut.hi, 32'd0);
        check("middiv_lo", dut.lo, 32'd0);
        issue(pack(mk(OP_ADD, 32'd2, 32'd3, 16'd0, C_WE, 16'd0)));
        check("post_rst_add_valid", es_to_ms_valid, 1'b1);
        check("post_rst_add_res", es_to_ms_bus[63:32], 32'd5);
        read_hilo(HR_MFLO, v);
        check("post_rst_lo", v, 32'd0);
`else
        // without the mul/div unit: mf reads the ALU, div does not stall
        read_hilo(HR_MFHI, v);
        check("nomd_mfhi_alu", v, 32'd7);
        issue(pack(md_ins(MD_DIV, 32'd8, 32'd2)));
        check("nomd_div_valid", es_to_ms_valid, 1'b1);
        check("nomd_div_allowin", es_allowin, 1'b1);
        check("nomd_div_res", es_to_ms_bus[63:32], 32'd10);
        issue(pack(md_ins(MD_DIV, 32'd8, 32'd2)));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("nomd_rst_valid", es_to_ms_valid, 1'b0);
        check("nomd_rst_allowin", es_allowin, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
